// File: rtl/division_inverse.sv
// Sequential shift-and-add reconstructor: dividend = quotient * divisor + remainder.
// Fixed latency of DATAWIDTH+1 edges from accept; enable/ready handshake matches the iterative divider.
module division_inverse #(
   parameter int DATAWIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic [DATAWIDTH-1:0] quotient,
   input  logic [DATAWIDTH-1:0] divisor,
   input  logic [DATAWIDTH-1:0] remainder,
   output logic                 ready,
   output logic [DATAWIDTH-1:0] dividend,
   output logic                 overflow,
   output logic                 rem_err
);

   localparam int CW = $clog2(DATAWIDTH) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DATAWIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      ADD
   } state_t;

   state_t state, state_nxt;

   logic [2*DATAWIDTH-1:0] mcand;
   logic [DATAWIDTH-1:0]   mplier;
   logic [2*DATAWIDTH:0]   acc;
   logic [DATAWIDTH-1:0]   rem_r;
   logic [CW-1:0]          cnt;

   logic [2*DATAWIDTH:0]   acc_mul;
   logic [2*DATAWIDTH:0]   acc_fin;

   assign acc_mul = acc + {1'b0, mcand};
   assign acc_fin = acc + {{(DATAWIDTH+1){1'b0}}, rem_r};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (enable) state_nxt = MUL;
         MUL:     if (cnt == CNT_LAST) state_nxt = ADD;
         ADD:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // MUL always runs the full DATAWIDTH steps so latency never depends on operand values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand    <= '0;
         mplier   <= '0;
         acc      <= '0;
         rem_r    <= '0;
         cnt      <= '0;
         ready    <= 1'b0;
         dividend <= '0;
         overflow <= 1'b0;
         rem_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (enable) begin
                  mcand    <= {{DATAWIDTH{1'b0}}, divisor};
                  mplier   <= quotient;
                  rem_r    <= remainder;
                  acc      <= '0;
                  cnt      <= '0;
                  rem_err  <= (remainder >= divisor);
                  ready    <= 1'b0;
                  overflow <= 1'b0;
               end
            end
            MUL: begin
               if (mplier[0]) acc <= acc_mul;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + CW'(1);
            end
            ADD: begin
               acc      <= acc_fin;
               dividend <= acc_fin[DATAWIDTH-1:0];
               overflow <= |acc_fin[2*DATAWIDTH:DATAWIDTH];
               ready    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_division_inverse.sv
// Self-checking bench for division_inverse: directed cases, back-to-back timing,
// random triples and a divide/recompose round trip against an arithmetic model.
module tb_division_inverse;

   localparam int W   = 32;
   localparam int LAT = W + 1;

   logic         clk;
   logic         rst_n;
   logic         enable;
   logic [W-1:0] quotient;
   logic [W-1:0] divisor;
   logic [W-1:0] remainder;
   logic         ready;
   logic [W-1:0] dividend;
   logic         overflow;
   logic         rem_err;

   int checks;
   int failures;

   division_inverse #(.DATAWIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable    (enable),
      .quotient  (quotient),
      .divisor   (divisor),
      .remainder (remainder),
      .ready     (ready),
      .dividend  (dividend),
      .overflow  (overflow),
      .rem_err   (rem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: full-precision unsigned arithmetic (max result fits in 64 bits).
   function automatic logic [63:0] model_full(input logic [W-1:0] q, d, r);
      return 64'(q) * 64'(d) + 64'(r);
   endfunction

   // Drive one accept, scramble inputs afterwards, and count edges until ready.
   task automatic run_op(input logic [W-1:0] q, d, r, output int lat);
      @(negedge clk);
      quotient  = q;
      divisor   = d;
      remainder = r;
      enable    = 1'b1;
      @(posedge clk);
      #1;
      enable    = 1'b0;
      quotient  = $urandom;
      divisor   = $urandom;
      remainder = $urandom;
      lat = 0;
      while (!ready && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", ready); end
      checks++;
      if (dividend !== '0) begin failures++; $display("FAIL reset_dividend got=%0h exp=0", dividend); end
      checks++;
      if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
      checks++;
      if (rem_err !== 1'b0) begin failures++; $display("FAIL reset_rem_err got=%0b exp=0", rem_err); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b0) begin failures++; $display("FAIL reset_idle_ready got=%0b exp=0", ready); end
   endtask

   task automatic test_basic;
      int lat;
      logic stable;
      run_op(32'd5, 32'd7, 32'd3, lat);
      checks++;
      if (lat != LAT) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT); end
      checks++;
      if (dividend !== 32'd38) begin failures++; $display("FAIL basic_dividend got=%0d exp=38", dividend); end
      checks++;
      if (overflow !== 1'b0 || rem_err !== 1'b0)
         begin failures++; $display("FAIL basic_flags got ov=%0b re=%0b exp ov=0 re=0", overflow, rem_err); end
      stable = 1'b1;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (ready !== 1'b1 || dividend !== 32'd38 || overflow !== 1'b0 || rem_err !== 1'b0) stable = 1'b0;
      end
      checks++;
      if (!stable) begin failures++; $display("FAIL basic_hold got ready=%0b dividend=%0d exp ready=1 dividend=38", ready, dividend); end
   endtask

   task automatic test_reset_midrun;
      @(negedge clk);
      quotient  = 32'd9;
      divisor   = 32'd9;
      remainder = 32'd0;
      enable    = 1'b1;
      @(posedge clk);
      #1;
      enable = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ready !== 1'b0 || dividend !== '0 || overflow !== 1'b0 || rem_err !== 1'b0)
         begin failures++; $display("FAIL midrun_reset got r=%0b d=%0h ov=%0b re=%0b exp all 0", ready, dividend, overflow, rem_err); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (50) @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b0 || dividend !== '0)
         begin failures++; $display("FAIL midrun_idle got r=%0b d=%0h exp r=0 d=0", ready, dividend); end
   endtask

   task automatic test_overflow;
      int lat;
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, lat);
      checks++;
      if (dividend !== 32'hFFFF_FFFF) begin failures++; $display("FAIL ovf_dividend got=%0h exp=ffffffff", dividend); end
      checks++;
      if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
      checks++;
      if (rem_err !== 1'b0) begin failures++; $display("FAIL ovf_rem_err got=%0b exp=0", rem_err); end
   endtask

   task automatic test_illegal;
      int lat;
      run_op(32'd3, 32'd0, 32'd12, lat);
      checks++;
      if (lat != LAT) begin failures++; $display("FAIL illegal_latency got=%0d exp=%0d", lat, LAT); end
      checks++;
      if (dividend !== 32'd12) begin failures++; $display("FAIL illegal_dividend got=%0d exp=12", dividend); end
      checks++;
      if (rem_err !== 1'b1 || overflow !== 1'b0)
         begin failures++; $display("FAIL illegal_flags got re=%0b ov=%0b exp re=1 ov=0", rem_err, overflow); end
      run_op(32'd0, 32'd50, 32'd17, lat);
      checks++;
      if (lat != LAT || dividend !== 32'd17 || rem_err !== 1'b0)
         begin failures++; $display("FAIL zero_quotient got lat=%0d d=%0d re=%0b exp lat=%0d d=17 re=0", lat, dividend, rem_err, LAT); end
   endtask

   task automatic test_back_to_back;
      int c1, c2;
      @(negedge clk);
      quotient  = 32'd10;
      divisor   = 32'd10;
      remainder = 32'd9;
      enable    = 1'b1;
      @(posedge clk);
      #1;
      c1 = 0;
      while (!ready && c1 < 100) begin
         enable    = 1'($urandom);
         quotient  = $urandom;
         divisor   = $urandom;
         remainder = $urandom;
         @(posedge clk);
         #1;
         c1++;
      end
      checks++;
      if (c1 != LAT) begin failures++; $display("FAIL b2b_first_latency got=%0d exp=%0d", c1, LAT); end
      checks++;
      if (dividend !== 32'd109 || overflow !== 1'b0 || rem_err !== 1'b0)
         begin failures++; $display("FAIL b2b_first_result got d=%0d ov=%0b re=%0b exp d=109 ov=0 re=0", dividend, overflow, rem_err); end
      // Completion edge is followed by the re-accept edge, then the full latency.
      quotient  = 32'd2;
      divisor   = 32'h8000_0000;
      remainder = 32'd0;
      enable    = 1'b1;
      c2 = 0;
      do begin
         @(posedge clk);
         #1;
         c2++;
      end while (!ready && c2 < 100);
      enable = 1'b0;
      checks++;
      if (c2 != LAT + 1) begin failures++; $display("FAIL b2b_gap got=%0d exp=%0d", c2, LAT + 1); end
      checks++;
      if (dividend !== 32'd0 || overflow !== 1'b1 || rem_err !== 1'b0)
         begin failures++; $display("FAIL b2b_second_result got d=%0h ov=%0b re=%0b exp d=0 ov=1 re=0", dividend, overflow, rem_err); end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_random;
      int lat;
      logic [W-1:0] q, d, r;
      logic [63:0]  full;
      for (int i = 0; i < 60; i++) begin
         q = $urandom;
         d = (i % 3 == 0) ? W'($urandom_range(0, 15)) : $urandom;
         r = (i % 4 == 0) ? 32'hFFFF_FFFF : $urandom;
         full = model_full(q, d, r);
         run_op(q, d, r, lat);
         checks++;
         if (lat != LAT || dividend !== full[W-1:0] || overflow !== (|full[63:W]) || rem_err !== (r >= d))
            begin
               failures++;
               $display("FAIL random_%0d q=%0h d=%0h r=%0h got lat=%0d d=%0h ov=%0b re=%0b exp lat=%0d d=%0h ov=%0b re=%0b",
                        i, q, d, r, lat, dividend, overflow, rem_err, LAT, full[W-1:0], |full[63:W], r >= d);
            end
      end
   endtask

   task automatic test_round_trip;
      int lat;
      logic [W-1:0] a, b, q, r;
      for (int i = 0; i < 200; i++) begin
         a = $urandom;
         b = (i % 2 == 0) ? W'($urandom_range(1, 1000)) : $urandom;
         if (b == 0) b = 1;
         q = a / b;
         r = a % b;
         run_op(q, b, r, lat);
         checks++;
         if (dividend !== a || overflow !== 1'b0 || rem_err !== 1'b0)
            begin
               failures++;
               $display("FAIL round_trip_%0d a=%0h b=%0h got d=%0h ov=%0b re=%0b exp d=%0h ov=0 re=0",
                        i, a, b, dividend, overflow, rem_err, a);
            end
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      enable    = 1'b0;
      quotient  = '0;
      divisor   = '0;
      remainder = '0;
      test_reset;
      test_basic;
      test_reset_midrun;
      test_overflow;
      test_illegal;
      test_back_to_back;
      test_random;
      test_round_trip;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
